adder_arbiter: RTL and testbench

//  Shares one n-bit adder (sum, carry-out, signed overflow) between two requesters.

---
 rtl/adder_arbiter.sv | 143 ++++++++++++++
 tb/tb_adder_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: one shared n-bit adder (sum, carry-out, signed overflow) serving
// two valid/ready requesters with round-robin arbitration and a held result port.
// Optional feature macro STICKY_OVF_EN adds ovf_clr / ovf_sticky.
module adder_arbiter #(
   parameter int unsigned n = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   input  logic [n-1:0] req0_x,
   input  logic [n-1:0] req0_y,
   output logic         req0_ready,
   input  logic         req1_valid,
   input  logic [n-1:0] req1_x,
   input  logic [n-1:0] req1_y,
   output logic         req1_ready,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [n-1:0] res_s,
   output logic         res_cout,
   output logic         res_ovf,
   output logic         res_id,
   output logic         busy
`ifdef STICKY_OVF_EN
   ,
   input  logic         ovf_clr,
   output logic         ovf_sticky
`endif
);

   localparam int unsigned SUM_W = n + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic             grant0;
   logic             grant1;
   logic             last_grant;
   logic [n-1:0]     op_x;
   logic [n-1:0]     op_y;
   logic             op_id;
   logic [SUM_W-1:0] sum_c;
   logic             ovf_c;

   // Next-state and grant decode; grants only exist in IDLE and out of reset
   always_comb begin
      state_nxt = state;
      grant0    = 1'b0;
      grant1    = 1'b0;
      case (state)
         IDLE: begin
            if (rst_n) begin
               if (req0_valid && (!req1_valid || last_grant)) begin
                  grant0 = 1'b1;
               end else if (req1_valid) begin
                  grant1 = 1'b1;
               end
            end
            if (grant0 || grant1) begin
               state_nxt = CALC;
            end
         end
         CALC: state_nxt = HOLD;
         HOLD: begin
            if (res_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign busy       = (state != IDLE);

   // Shared adder on the captured operands
   assign sum_c = {1'b0, op_x} + {1'b0, op_y};
   assign ovf_c = (op_x[n-1] & op_y[n-1] & ~sum_c[n-1]) |
                  (~op_x[n-1] & ~op_y[n-1] & sum_c[n-1]);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Operand capture, result registers and round-robin history
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_x       <= '0;
         op_y       <= '0;
         op_id      <= 1'b0;
         last_grant <= 1'b1;
         res_s      <= '0;
         res_cout   <= 1'b0;
         res_ovf    <= 1'b0;
         res_id     <= 1'b0;
         res_valid  <= 1'b0;
      end else begin
         if (grant0) begin
            op_x  <= req0_x;
            op_y  <= req0_y;
            op_id <= 1'b0;
         end else if (grant1) begin
            op_x  <= req1_x;
            op_y  <= req1_y;
            op_id <= 1'b1;
         end
         if (state == CALC) begin
            res_s     <= sum_c[n-1:0];
            res_cout  <= sum_c[n];
            res_ovf   <= ovf_c;
            res_id    <= op_id;
            res_valid <= 1'b1;
         end
         if (state == HOLD && res_valid && res_ready) begin
            res_valid  <= 1'b0;
            last_grant <= res_id;
         end
      end
   end

`ifdef STICKY_OVF_EN
   // Sticky overflow flag; a set on this cycle's handshake beats a clear
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_sticky <= 1'b0;
      end else if (res_valid && res_ready && res_ovf) begin
         ovf_sticky <= 1'b1;
      end else if (ovf_clr) begin
         ovf_sticky <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter (n=4); define STICKY_OVF_EN to cover the sticky flag.
module tb_adder_arbiter;

   localparam int unsigned N = 4;

   typedef struct packed {
      logic [N-1:0] s;
      logic         cout;
      logic         ovf;
      logic         id;
   } res_t;

   typedef struct packed {
      logic [N-1:0] x;
      logic [N-1:0] y;
   } op_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req0_valid = 1'b0;
   logic [N-1:0] req0_x = '0;
   logic [N-1:0] req0_y = '0;
   logic         req0_ready;
   logic         req1_valid = 1'b0;
   logic [N-1:0] req1_x = '0;
   logic [N-1:0] req1_y = '0;
   logic         req1_ready;
   logic         res_valid;
   logic         res_ready = 1'b1;
   logic [N-1:0] res_s;
   logic         res_cout;
   logic         res_ovf;
   logic         res_id;
   logic         busy;
`ifdef STICKY_OVF_EN
   logic         ovf_clr = 1'b0;
   logic         ovf_sticky;
`endif

   int   vectors = 0;
   int   miscompares = 0;
   op_t  src0[$];
   op_t  src1[$];
   res_t sb[$];
   res_t seen[$];
   logic [1:0] m_st = 2'd0;
   logic m_lg = 1'b1;
   logic m_rv = 1'b0;
   logic acc0 = 1'b0;
   logic acc1 = 1'b0;

   adder_arbiter #(.n(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_x     (req0_x),
      .req0_y     (req0_y),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_x     (req1_x),
      .req1_y     (req1_y),
      .req1_ready (req1_ready),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_s      (res_s),
      .res_cout   (res_cout),
      .res_ovf    (res_ovf),
      .res_id     (res_id),
      .busy       (busy)
`ifdef STICKY_OVF_EN
      ,
      .ovf_clr    (ovf_clr),
      .ovf_sticky (ovf_sticky)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   function automatic res_t ref_result(input logic [N-1:0] x, input logic [N-1:0] y, input logic id);
      int   ux, uy, sx, sy, us, ss;
      res_t r;
      ux = int'(x);
      uy = int'(y);
      sx = x[N-1] ? ux - (1 << N) : ux;
      sy = y[N-1] ? uy - (1 << N) : uy;
      us = ux + uy;
      ss = sx + sy;
      r.s    = N'(us);
      r.cout = (us >= (1 << N));
      r.ovf  = (ss > (1 << (N-1)) - 1) || (ss < -(1 << (N-1)));
      r.id   = id;
      return r;
   endfunction

   function automatic op_t mk_op(input logic [N-1:0] x, input logic [N-1:0] y);
      op_t o;
      o.x = x;
      o.y = y;
      return o;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Requester agents: offer the queue head, hold it stable until accepted
   always @(posedge clk) begin
      #1;
      if (acc0 && src0.size() != 0) void'(src0.pop_front());
      if (acc1 && src1.size() != 0) void'(src1.pop_front());
      req0_valid = (src0.size() != 0);
      if (req0_valid) {req0_x, req0_y} = src0[0];
      req1_valid = (src1.size() != 0);
      if (req1_valid) {req1_x, req1_y} = src1[0];
   end

   // Reference model of the arbiter: expected results pushed at acceptance
   always @(posedge clk) begin : model
      logic g0, g1;
      g0 = (m_st == 2'd0) && req0_valid && (!req1_valid || m_lg);
      g1 = (m_st == 2'd0) && req1_valid && (!req0_valid || !m_lg);
      if (!rst_n) begin
         m_st = 2'd0;
         m_lg = 1'b1;
         m_rv = 1'b0;
         sb.delete();
      end else begin
         case (m_st)
            2'd0: begin
               if (g0) begin
                  sb.push_back(ref_result(req0_x, req0_y, 1'b0));
                  m_st = 2'd1;
               end else if (g1) begin
                  sb.push_back(ref_result(req1_x, req1_y, 1'b1));
                  m_st = 2'd1;
               end
            end
            2'd1: begin
               m_st = 2'd2;
               m_rv = 1'b1;
            end
            default: begin
               if (res_ready) begin
                  if (sb.size() != 0) begin
                     m_lg = sb[0].id;
                     void'(sb.pop_front());
                  end
                  m_rv = 1'b0;
                  m_st = 2'd0;
               end
            end
         endcase
      end
   end

   // Per-cycle comparison of handshakes and held result against the model
   always @(negedge clk) begin : monitor
      logic e0, e1;
      e0 = rst_n && (m_st == 2'd0) && req0_valid && (!req1_valid || m_lg);
      e1 = rst_n && (m_st == 2'd0) && req1_valid && (!req0_valid || !m_lg);
      check("req0_ready", 32'(req0_ready), 32'(e0));
      check("req1_ready", 32'(req1_ready), 32'(e1));
      check("busy", 32'(busy), 32'(m_st != 2'd0));
      check("res_valid", 32'(res_valid), 32'(m_rv));
      if (m_rv && sb.size() != 0)
         check("result", 32'({res_s, res_cout, res_ovf, res_id}), 32'(sb[0]));
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      if (res_valid && res_ready) seen.push_back({res_s, res_cout, res_ovf, res_id});
   end

   task automatic wait_for(input int which, input string tag);
      int   n = 0;
      logic hit = 1'b0;
      while (!hit && n < 50) begin
         @(negedge clk);
         n++;
         case (which)
            0:       hit = res_valid;
            1:       hit = req0_ready;
            default: hit = req1_ready;
         endcase
      end
      check(tag, 32'(hit), 32'd1);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((src0.size() != 0 || src1.size() != 0 || req0_valid || req1_valid || m_st != 2'd0)
             && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(n < 200), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held with both requesters valid
      src0.push_back(mk_op(4'd5, 4'd6));
      src1.push_back(mk_op(4'd8, 4'd8));
      repeat (2) begin
         @(negedge clk);
         check("rst_res_valid", 32'(res_valid), 32'd0);
         check("rst_res_s", 32'(res_s), 32'd0);
         check("rst_res_cout", 32'(res_cout), 32'd0);
         check("rst_res_ovf", 32'(res_ovf), 32'd0);
         check("rst_busy", 32'(busy), 32'd0);
         check("rst_req0_ready", 32'(req0_ready), 32'd0);
         check("rst_req1_ready", 32'(req1_ready), 32'd0);
      end
      step();
      rst_n = 1'b1;

      // Both valid after reset: req0 served first, then req1
      wait_idle("t3_drain");
      check("t3_count", 32'(seen.size()), 32'd2);
      if (seen.size() == 2) begin
         check("t3_first", 32'(seen[0]), 32'({4'hB, 1'b0, 1'b1, 1'b0}));
         check("t3_second", 32'(seen[1]), 32'({4'h0, 1'b1, 1'b1, 1'b1}));
      end

      // Continuous contention with a 5-cycle consumer stall on the first result
      seen.delete();
      step();
      res_ready = 1'b0;
      src0.push_back(mk_op(4'd1, 4'd2));
      src0.push_back(mk_op(4'd7, 4'd7));
      src1.push_back(mk_op(4'd4, 4'd5));
      src1.push_back(mk_op(4'd9, 4'd9));
      wait_for(0, "t4_first_valid");
      repeat (5) begin
         @(negedge clk);
         check("t4_stall_valid", 32'(res_valid), 32'd1);
         check("t4_stall_ready0", 32'(req0_ready), 32'd0);
         check("t4_stall_ready1", 32'(req1_ready), 32'd0);
         check("t4_stall_s", 32'(res_s), 32'h3);
      end
      step();
      res_ready = 1'b1;
      wait_idle("t4_drain");
      check("t4_count", 32'(seen.size()), 32'd4);
      for (int k = 0; k < 4; k++)
         if (k < seen.size()) check("t4_id", 32'(seen[k].id), 32'(k % 2));

      // Single requester latency
      seen.delete();
      src0.push_back(mk_op(4'd3, 4'd4));
      wait_for(1, "t2_grant");
      @(negedge clk);
      check("t2_ready_pulse", 32'(req0_ready), 32'd0);
      check("t2_lat_t1", 32'(res_valid), 32'd0);
      @(negedge clk);
      check("t2_lat_t2", 32'(res_valid), 32'd1);
      wait_idle("t2_drain");
      check("t2_count", 32'(seen.size()), 32'd1);
      if (seen.size() == 1) check("t2_result", 32'(seen[0]), 32'({4'h7, 1'b0, 1'b0, 1'b0}));

      // Reset during CALC of req1 (last grant 0), then both valid
      seen.delete();
      src1.push_back(mk_op(4'd2, 4'd2));
      wait_for(2, "t5_grant1");
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      src0.push_back(mk_op(4'd3, 4'd3));
      src1.push_back(mk_op(4'd4, 4'd4));
      @(negedge clk);
      check("t5_res_valid", 32'(res_valid), 32'd0);
      wait_idle("t5_drain");
      check("t5_count", 32'(seen.size()), 32'd2);
      if (seen.size() == 2) begin
         check("t5_first_id", 32'(seen[0].id), 32'd0);
         check("t5_first", 32'(seen[0]), 32'({4'h6, 1'b0, 1'b0, 1'b0}));
         check("t5_second", 32'(seen[1]), 32'({4'h8, 1'b0, 1'b1, 1'b1}));
      end

`ifdef STICKY_OVF_EN
      // Sticky overflow set, set-beats-clear, then clear
      seen.delete();
      src0.push_back(mk_op(4'hF, 4'h1));
      wait_idle("t6_drain1");
      if (seen.size() == 1) check("t6_first", 32'(seen[0]), 32'({4'h0, 1'b1, 1'b0, 1'b0}));
      check("t6_sticky0", 32'(ovf_sticky), 32'd0);
      seen.delete();
      src0.push_back(mk_op(4'h7, 4'h1));
      wait_idle("t6_drain2");
      if (seen.size() == 1) check("t6_second_ovf", 32'(seen[0].ovf), 32'd1);
      check("t6_sticky1", 32'(ovf_sticky), 32'd1);
      step();
      res_ready = 1'b0;
      src0.push_back(mk_op(4'h7, 4'h1));
      wait_for(0, "t6_valid");
      step();
      ovf_clr   = 1'b1;
      res_ready = 1'b1;
      step();
      ovf_clr = 1'b0;
      @(negedge clk);
      check("t6_set_wins", 32'(ovf_sticky), 32'd1);
      wait_idle("t6_drain3");
      step();
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      @(negedge clk);
      check("t6_cleared", 32'(ovf_sticky), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
